ltl_automata_engine: RTL and testbench

Runtime-programmable, parametrised homogeneous automaton engine for the LTL runtime monitors. It replaces per-property fixed STE netlists with one engine whose state count, symbol width, match intervals, transition matrix, start types and report mask are loaded over a configuration port. The engine consumes one trace symbol per cycle from the core-side monitor tap and emits per-state report vectors, a sticky violation flag and trace-position bookkeeping.

---
 rtl/ltl_mon_pkg.sv | 34 +++
 rtl/ltl_ste_match.sv | 23 ++
 rtl/ltl_automata_engine.sv | 163 ++++++++++++++++
 tb/tb_ltl_automata_engine.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltl_mon_pkg.sv
// Shared types and defaults for the LTL runtime-monitor automaton engine.
package ltl_mon_pkg;

  // How an STE becomes enabled independent of its predecessors.
  typedef enum logic [1:0] {
    START_NONE = 2'd0,
    START_SOD  = 2'd1,
    START_ALL  = 2'd2
  } start_type_e;

  // Configuration write targets; any other encoding is rejected.
  typedef enum logic [2:0] {
    CFG_ADJ    = 3'd0,
    CFG_LO     = 3'd1,
    CFG_HI     = 3'd2,
    CFG_START  = 3'd3,
    CFG_REPORT = 3'd4
  } cfg_sel_e;

  localparam int DEF_NUM_STE = 16;
  localparam int DEF_SYM_W   = 8;
  localparam int DEF_NUM_IV  = 4;
  localparam int DEF_CNT_W   = 32;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ltl_ste_match.sv
// Symbol matcher for one STE: a symbol matches when it falls inside any of
// the STE's inclusive [lo, hi] intervals. An interval with lo > hi is empty.
module ltl_ste_match
  import ltl_mon_pkg::*;
#(
  parameter int SYM_W  = DEF_SYM_W,
  parameter int NUM_IV = DEF_NUM_IV
) (
  input  logic [SYM_W-1:0]             i_sym,
  input  logic [NUM_IV-1:0][SYM_W-1:0] i_lo,
  input  logic [NUM_IV-1:0][SYM_W-1:0] i_hi,
  output logic                         o_match
);

  // OR of all interval comparisons.
  always_comb begin
    o_match = 1'b0;
    for (int k = 0; k < NUM_IV; k++) begin
      if ((i_sym >= i_lo[k]) && (i_sym <= i_hi[k])) o_match = 1'b1;
    end
  end

endmodule

// File: rtl/ltl_automata_engine.sv
// Runtime-programmable homogeneous automaton engine. Consumes one trace
// symbol per accepted cycle and reports which reporting STEs became active.
//
// Handshake: a symbol is consumed on a rising clock edge where
// sym_valid_i & sym_ready_o, with sym_ready_o = run_i & ~clear_i. The
// report side has no backpressure: rpt_valid_o is a one-cycle pulse in the
// cycle after each acceptance.
module ltl_automata_engine
  import ltl_mon_pkg::*;
#(
  parameter int NUM_STE = DEF_NUM_STE,
  parameter int SYM_W   = DEF_SYM_W,
  parameter int NUM_IV  = DEF_NUM_IV,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 run_i,
  input  logic                                 clear_i,
  input  logic                                 sym_valid_i,
  output logic                                 sym_ready_o,
  input  logic [SYM_W-1:0]                     sym_i,
  input  logic                                 cfg_we_i,
  input  logic [2:0]                           cfg_sel_i,
  input  logic [clog2_min1(NUM_STE)-1:0]       cfg_idx_i,
  input  logic [clog2_min1(NUM_IV)-1:0]        cfg_sub_i,
  input  logic [max_int(NUM_STE,SYM_W)-1:0]    cfg_wdata_i,
  output logic                                 cfg_err_o,
  output logic                                 rpt_valid_o,
  output logic [NUM_STE-1:0]                   rpt_o,
  output logic                                 violation_o,
  output logic [CNT_W-1:0]                     first_rpt_idx_o,
  output logic [CNT_W-1:0]                     sym_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Configuration state
  logic [NUM_STE-1:0][NUM_STE-1:0]            r_adj;    // r_adj[j][i]: edge j->i
  logic [NUM_STE-1:0][NUM_IV-1:0][SYM_W-1:0]  r_lo;
  logic [NUM_STE-1:0][NUM_IV-1:0][SYM_W-1:0]  r_hi;
  logic [NUM_STE-1:0][1:0]                    r_start;
  logic [NUM_STE-1:0]                         r_report;

  // Stream state
  logic [NUM_STE-1:0] r_act;
  logic               r_sod;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_first;
  logic               r_viol;
  logic [NUM_STE-1:0] r_rpt;
  logic               r_rpt_valid;
  logic               r_cfg_err;

  logic               w_accept;
  logic               w_sel_known;
  logic               w_cfg_ok;
  logic [NUM_STE-1:0] w_match;
  logic [NUM_STE-1:0] w_en;
  logic [NUM_STE-1:0] w_next;
  logic [NUM_STE-1:0] w_rpt;

  assign sym_ready_o = run_i & ~clear_i;
  assign w_accept    = sym_valid_i & sym_ready_o;
  assign w_sel_known = cfg_sel_i inside {CFG_ADJ, CFG_LO, CFG_HI, CFG_START, CFG_REPORT};
  assign w_cfg_ok    = cfg_we_i & ~run_i & w_sel_known;

  for (genvar g = 0; g < NUM_STE; g++) begin : g_ste
    ltl_ste_match #(
      .SYM_W  (SYM_W),
      .NUM_IV (NUM_IV)
    ) u_match (
      .i_sym   (sym_i),
      .i_lo    (r_lo[g]),
      .i_hi    (r_hi[g]),
      .o_match (w_match[g])
    );
  end

  // Enable of each STE: start condition or any active predecessor.
  always_comb begin
    w_en = '0;
    for (int i = 0; i < NUM_STE; i++) begin
      logic v_en;
      v_en = (r_start[i] == START_ALL) | ((r_start[i] == START_SOD) & r_sod);
      for (int j = 0; j < NUM_STE; j++) begin
        v_en = v_en | (r_act[j] & r_adj[j][i]);
      end
      w_en[i] = v_en;
    end
  end

  assign w_next = w_en & w_match;
  assign w_rpt  = w_next & r_report;

  // Configuration registers: written only while the engine is stopped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_adj    <= '0;
      r_lo     <= '1;
      r_hi     <= '0;
      r_start  <= '0;
      r_report <= '0;
    end else if (w_cfg_ok) begin
      case (cfg_sel_i)
        CFG_ADJ:    r_adj[cfg_idx_i]             <= cfg_wdata_i[NUM_STE-1:0];
        CFG_LO:     r_lo[cfg_idx_i][cfg_sub_i]   <= cfg_wdata_i[SYM_W-1:0];
        CFG_HI:     r_hi[cfg_idx_i][cfg_sub_i]   <= cfg_wdata_i[SYM_W-1:0];
        CFG_START:  r_start[cfg_idx_i]           <= cfg_wdata_i[1:0];
        CFG_REPORT: r_report[cfg_idx_i]          <= cfg_wdata_i[0];
        default:    ;
      endcase
    end
  end

  // Rejected-write pulse, one cycle after the offending strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cfg_err <= 1'b0;
    else         r_cfg_err <= cfg_we_i & (run_i | ~w_sel_known);
  end

  // Active vector, counters and report bookkeeping; clear restarts the stream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_act       <= '0;
      r_sod       <= 1'b1;
      r_cnt       <= '0;
      r_first     <= '0;
      r_viol      <= 1'b0;
      r_rpt       <= '0;
      r_rpt_valid <= 1'b0;
    end else if (clear_i) begin
      r_act       <= '0;
      r_sod       <= 1'b1;
      r_cnt       <= '0;
      r_first     <= '0;
      r_viol      <= 1'b0;
      r_rpt       <= '0;
      r_rpt_valid <= 1'b0;
    end else if (w_accept) begin
      r_act       <= w_next;
      r_sod       <= 1'b0;
      r_rpt       <= w_rpt;
      r_rpt_valid <= 1'b1;
      if (r_cnt != '1) r_cnt <= r_cnt + CNT_ONE;
      if ((|w_rpt) && !r_viol) begin
        r_viol  <= 1'b1;
        r_first <= r_cnt;
      end
    end else begin
      r_rpt       <= '0;
      r_rpt_valid <= 1'b0;
    end
  end

  assign cfg_err_o       = r_cfg_err;
  assign rpt_valid_o     = r_rpt_valid;
  assign rpt_o           = r_rpt;
  assign violation_o     = r_viol;
  assign first_rpt_idx_o = r_first;
  assign sym_cnt_o       = r_cnt;

endmodule

// File: tb/tb_ltl_automata_engine.sv
// Directed and randomized bench for ltl_automata_engine with a set-based
// reference model. A second instance with a 4-bit counter runs the same
// stimulus to cover counter saturation.
module tb_ltl_automata_engine;
  import ltl_mon_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n, run, clear, sym_valid, cfg_we;
  logic [7:0]  sym;
  logic [2:0]  cfg_sel;
  logic [3:0]  cfg_idx;
  logic [1:0]  cfg_sub;
  logic [15:0] cfg_wdata;

  logic        sym_ready, cfg_err, rpt_valid, viol;
  logic [15:0] rpt;
  logic [31:0] first, cnt;
  logic        sym_ready4, cfg_err4, rpt_valid4, viol4;
  logic [15:0] rpt4;
  logic [3:0]  first4, cnt4;

  always #5 clk = ~clk;

  ltl_automata_engine dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .clear_i(clear),
    .sym_valid_i(sym_valid), .sym_ready_o(sym_ready), .sym_i(sym),
    .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_idx_i(cfg_idx),
    .cfg_sub_i(cfg_sub), .cfg_wdata_i(cfg_wdata), .cfg_err_o(cfg_err),
    .rpt_valid_o(rpt_valid), .rpt_o(rpt), .violation_o(viol),
    .first_rpt_idx_o(first), .sym_cnt_o(cnt)
  );

  ltl_automata_engine #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .clear_i(clear),
    .sym_valid_i(sym_valid), .sym_ready_o(sym_ready4), .sym_i(sym),
    .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_idx_i(cfg_idx),
    .cfg_sub_i(cfg_sub), .cfg_wdata_i(cfg_wdata), .cfg_err_o(cfg_err4),
    .rpt_valid_o(rpt_valid4), .rpt_o(rpt4), .violation_o(viol4),
    .first_rpt_idx_o(first4), .sym_cnt_o(cnt4)
  );

  // ---------------- reference model ----------------
  bit [15:0] m_adj [16];
  bit [7:0]  m_lo  [16][4];
  bit [7:0]  m_hi  [16][4];
  bit [1:0]  m_start [16];
  bit [15:0] m_rep;
  bit [15:0] m_act;
  bit        m_sod, m_viol, m_rv, m_err;
  longint    m_cnt, m_first;
  bit [15:0] m_rpt;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_adj[i] = '0;
      m_start[i] = 2'd0;
      for (int k = 0; k < 4; k++) begin
        m_lo[i][k] = 8'hFF;
        m_hi[i][k] = 8'h00;
      end
    end
    m_rep = '0; m_act = '0; m_sod = 1'b1; m_viol = 1'b0; m_rv = 1'b0;
    m_err = 1'b0; m_cnt = 0; m_first = 0; m_rpt = '0;
  endfunction

  function automatic bit in_language(int ste, bit [7:0] s);
    for (int k = 0; k < 4; k++)
      if (s >= m_lo[ste][k] && s <= m_hi[ste][k]) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one clock edge of the specified behaviour to the model using the
  // inputs currently driven.
  function automatic void model_edge();
    int active[$];
    bit [15:0] nxt;
    if (clear) begin
      m_act = '0; m_sod = 1'b1; m_cnt = 0; m_viol = 1'b0; m_first = 0;
      m_rpt = '0; m_rv = 1'b0;
    end else if (sym_valid && run) begin
      for (int j = 0; j < 16; j++) if (m_act[j]) active.push_back(j);
      nxt = '0;
      for (int i = 0; i < 16; i++) begin
        bit en;
        en = (m_start[i] == 2'd2) || (m_start[i] == 2'd1 && m_sod);
        foreach (active[a]) if (m_adj[active[a]][i]) en = 1'b1;
        nxt[i] = en && in_language(i, sym);
      end
      m_rpt = nxt & m_rep;
      m_rv = 1'b1;
      if (m_rpt != 0 && !m_viol) begin
        m_viol = 1'b1;
        m_first = m_cnt;
      end
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_act = nxt;
      m_sod = 1'b0;
    end else begin
      m_rpt = '0; m_rv = 1'b0;
    end
    m_err = cfg_we && (run || cfg_sel > 3'd4);
    if (cfg_we && !run && cfg_sel <= 3'd4) begin
      case (cfg_sel)
        3'd0: m_adj[cfg_idx] = cfg_wdata;
        3'd1: m_lo[cfg_idx][cfg_sub] = cfg_wdata[7:0];
        3'd2: m_hi[cfg_idx][cfg_sub] = cfg_wdata[7:0];
        3'd3: m_start[cfg_idx] = cfg_wdata[1:0];
        default: m_rep[cfg_idx] = cfg_wdata[0];
      endcase
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    exp_q.push_back(expv);
    assert (obs === exp_q.pop_front()) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    longint c4;
    c4 = (m_cnt > 15) ? 15 : m_cnt;
    chk("rpt_valid", rpt_valid, m_rv);
    chk("rpt", rpt, m_rpt);
    chk("violation", viol, m_viol);
    chk("first_rpt_idx", first, m_first);
    chk("sym_cnt", cnt, m_cnt);
    chk("cfg_err", cfg_err, m_err);
    chk("sym_ready", sym_ready, run & ~clear);
    chk("c4_rpt", rpt4, m_rpt);
    chk("c4_sym_cnt", cnt4, c4);
    chk("c4_first_rpt_idx", first4, (m_first > 15) ? 15 : m_first);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cfg_write(input logic [2:0] sel, input int idx, input int sub, input logic [15:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = 4'(idx); cfg_sub = 2'(sub); cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] s);
    sym_valid = 1'b1; sym = s;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; run = 1'b0; clear = 1'b0; sym_valid = 1'b0; cfg_we = 1'b0;
    sym = '0; cfg_sel = '0; cfg_idx = '0; cfg_sub = '0; cfg_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Single SOD state, reports on first symbol only.
    cfg_write(3'(CFG_LO), 0, 0, 16'h0000);
    cfg_write(3'(CFG_HI), 0, 0, 16'h000F);
    cfg_write(3'(CFG_START), 0, 0, 16'(START_SOD));
    cfg_write(3'(CFG_REPORT), 0, 0, 16'h0001);
    run = 1'b1;
    send(8'h05);
    chk("sod_first_rpt", rpt, 16'h0001);
    send(8'h05);
    chk("sod_second_rpt", rpt, 16'h0000);
    chk("sod_violation", viol, 1'b1);
    chk("sod_first_idx", first, 32'd0);
    chk("sod_cnt", cnt, 32'd2);
    run = 1'b0;

    // ALL-start state feeding a reporting successor.
    cfg_write(3'(CFG_LO), 0, 0, 16'h0010);
    cfg_write(3'(CFG_HI), 0, 0, 16'h001F);
    cfg_write(3'(CFG_START), 0, 0, 16'(START_ALL));
    cfg_write(3'(CFG_REPORT), 0, 0, 16'h0000);
    cfg_write(3'(CFG_LO), 1, 0, 16'h0080);
    cfg_write(3'(CFG_HI), 1, 0, 16'h00FF);
    cfg_write(3'(CFG_REPORT), 1, 0, 16'h0001);
    cfg_write(3'(CFG_ADJ), 0, 0, 16'h0002);
    do_clear();
    run = 1'b1;
    send(8'h90);
    chk("chain_rpt0", rpt, 16'h0000);
    send(8'h12);
    chk("chain_rpt1", rpt, 16'h0000);
    send(8'h90);
    chk("chain_rpt2", rpt, 16'h0002);
    chk("chain_first_idx", first, 32'd2);
    run = 1'b0;

    // Self-loop across a pause.
    cfg_write(3'(CFG_REPORT), 1, 0, 16'h0000);
    cfg_write(3'(CFG_LO), 0, 0, 16'h0000);
    cfg_write(3'(CFG_HI), 0, 0, 16'h007F);
    cfg_write(3'(CFG_START), 0, 0, 16'(START_SOD));
    cfg_write(3'(CFG_REPORT), 0, 0, 16'h0001);
    cfg_write(3'(CFG_ADJ), 0, 0, 16'h0001);
    do_clear();
    run = 1'b1;
    send(8'h01);
    chk("loop_rpt_a", rpt, 16'h0001);
    run = 1'b0;
    sym_valid = 1'b1; sym = 8'h33;
    repeat (5) begin
      tick();
      chk("pause_no_valid", rpt_valid, 1'b0);
    end
    sym_valid = 1'b0;
    run = 1'b1;
    send(8'h02);
    chk("loop_rpt_b", rpt, 16'h0001);
    chk("loop_cnt", cnt, 32'd2);

    // Write while running is rejected; hi bound stays 0x7F.
    cfg_write(3'(CFG_HI), 0, 0, 16'h0000);
    chk("cfg_err_pulse", cfg_err, 1'b1);
    send(8'h50);
    chk("cfg_unchanged", rpt, 16'h0001);
    run = 1'b0;
    cfg_write(3'd7, 0, 0, 16'h0000);
    chk("cfg_err_bad_sel", cfg_err, 1'b1);

    // Clear beats a simultaneous valid symbol.
    run = 1'b1;
    clear = 1'b1; sym_valid = 1'b1; sym = 8'h05;
    tick();
    clear = 1'b0; sym_valid = 1'b0;
    chk("clear_cnt", cnt, 32'd0);
    chk("clear_viol", viol, 1'b0);
    chk("clear_no_valid", rpt_valid, 1'b0);
    send(8'h03);
    chk("clear_then_sod", rpt, 16'h0001);

    // Counter saturation on the 4-bit instance.
    do_clear();
    send(8'h01);
    for (int n = 0; n < 19; n++) send(8'($urandom_range(0, 255)));
    chk("sat_c4_cnt", cnt4, 4'd15);
    chk("sat_cnt", cnt, 32'd20);

    // Asynchronous reset mid-stream with state active and violation set.
    run = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_violation", viol, 1'b0);
    chk("rst_ready", sym_ready, 1'b0);
    #2;
    rst_n = 1'b1;

    // Randomized configuration.
    for (int i = 0; i < 16; i++) begin
      int lo, w;
      lo = $urandom_range(0, 255);
      w  = $urandom_range(0, 64);
      cfg_write(3'(CFG_LO), i, 0, 16'(lo));
      cfg_write(3'(CFG_HI), i, 0, 16'((lo + w > 255) ? 255 : lo + w));
      cfg_write(3'(CFG_START), i, 0, 16'($urandom_range(0, 3)));
      cfg_write(3'(CFG_ADJ), i, 0, 16'($urandom & $urandom));
      cfg_write(3'(CFG_REPORT), i, 0, 16'($urandom_range(0, 1)));
    end

    // Randomized stream with pauses, clears and stray config writes.
    do_clear();
    for (int n = 0; n < 400; n++) begin
      run       = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      sym_valid = ($urandom_range(0, 4) != 0);
      sym       = 8'($urandom_range(0, 255));
      cfg_we    = ($urandom_range(0, 19) == 0);
      cfg_sel   = 3'($urandom_range(0, 7));
      cfg_idx   = 4'($urandom_range(0, 15));
      cfg_sub   = 2'($urandom_range(0, 3));
      cfg_wdata = 16'($urandom);
      tick();
    end
    run = 1'b0; clear = 1'b0; sym_valid = 1'b0; cfg_we = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
